// File: rtl/hand_raster_engine.sv
// Radial-hand rasteriser into a double-buffered 1-bpp framebuffer with scaled VGA scan-out.
// Hands are drawn one pixel per cycle using an external sin/cos unit over a start/done handshake.
module hand_raster_engine #(
  parameter int FB_DIM    = 64,
  parameter int SCALE     = 7,
  parameter int NUM_HANDS = 4,
  parameter int LEN_W     = 6,
  parameter int FRAC      = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_req,
  input  logic [9*NUM_HANDS-1:0]     hand_angle,
  input  logic [LEN_W*NUM_HANDS-1:0] hand_len,
  input  logic [NUM_HANDS-1:0]       hand_en,
  output logic                       trig_start,
  output logic [15:0]                trig_angle,
  input  logic [15:0]                trig_sin,
  input  logic [15:0]                trig_cos,
  input  logic                       trig_done,
  input  logic [9:0]                 horizCounter,
  input  logic [9:0]                 vertCounter,
  input  logic [9:0]                 x_offset,
  input  logic [9:0]                 y_offset,
  output logic                       pixel_bw,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int ROW_W = $clog2(FB_DIM);
  localparam int IDX_W = $clog2(NUM_HANDS + 1);
  localparam int CUR_W = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int PW    = LEN_W + 17;
  localparam logic [9:0] SCALE_V = 10'(SCALE);
  localparam logic [9:0] AREA_V  = 10'(FB_DIM * SCALE);
  localparam logic signed [PW:0] CENTRE = (PW + 1)'(FB_DIM / 2);

  typedef enum logic [2:0] {IDLE, CLEAR, SEL, REQ, WAIT, PLOT, SWAP} state_t;

  state_t                     state_reg, state_next;
  logic                       front_reg, front_next;
  logic                       valid_reg, valid_next;
  logic                       pending_reg, pending_next;
  logic                       req_d_reg;
  logic [9*NUM_HANDS-1:0]     angle_reg, angle_next;
  logic [LEN_W*NUM_HANDS-1:0] len_reg, len_next;
  logic [NUM_HANDS-1:0]       en_reg, en_next;
  logic [CUR_W-1:0]           cur_reg, cur_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [ROW_W-1:0]           row_reg, row_next;
  logic [LEN_W-1:0]           r_reg, r_next;
  logic                       sin_neg_reg, sin_neg_next;
  logic                       cos_neg_reg, cos_neg_next;
  logic [16:0]                sin_mag_reg, sin_mag_next;
  logic [16:0]                cos_mag_reg, cos_mag_next;
  logic                       pixel_next;

  logic [8:0]       ang_arr [NUM_HANDS];
  logic [LEN_W-1:0] len_arr [NUM_HANDS];
  logic [NUM_HANDS-1:0] hand_ok;

  generate
    for (genvar gi = 0; gi < NUM_HANDS; gi++) begin : g_hand
      assign ang_arr[gi] = angle_reg[9*gi +: 9];
      assign len_arr[gi] = len_reg[LEN_W*gi +: LEN_W];
      assign hand_ok[gi] = en_reg[gi] & (|len_reg[LEN_W*gi +: LEN_W]);
    end
  endgenerate

  function automatic logic [16:0] mag17(input logic [15:0] v);
    return v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  logic req_edge;
  assign req_edge = frame_req & ~req_d_reg;

  // First qualifying hand at or after the search position.
  logic             found;
  logic [IDX_W-1:0] sel_pos;
  always_comb begin
    found   = 1'b0;
    sel_pos = '0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (!found && hand_ok[i] && (i >= int'(idx_reg))) begin
        found   = 1'b1;
        sel_pos = IDX_W'(i);
      end
    end
  end

  logic [8:0] cur_ang, clamp_ang;
  assign cur_ang   = ang_arr[cur_reg];
  assign clamp_ang = (cur_ang > 9'd359) ? 9'd359 : cur_ang;

  // Offsets use magnitude truncation so the figure stays symmetric about the centre.
  logic [PW-1:0]        prod_s, prod_c, off_s, off_c;
  logic signed [PW:0]   x_pos, y_pos;
  logic                 plot_ok;
  assign prod_s  = PW'(r_reg) * PW'(sin_mag_reg);
  assign prod_c  = PW'(r_reg) * PW'(cos_mag_reg);
  assign off_s   = prod_s >> FRAC;
  assign off_c   = prod_c >> FRAC;
  assign x_pos   = sin_neg_reg ? (CENTRE - $signed({1'b0, off_s})) : (CENTRE + $signed({1'b0, off_s}));
  assign y_pos   = cos_neg_reg ? (CENTRE + $signed({1'b0, off_c})) : (CENTRE - $signed({1'b0, off_c}));
  assign plot_ok = (x_pos[PW:ROW_W] == '0) && (y_pos[PW:ROW_W] == '0);

  always_comb begin
    state_next   = state_reg;
    front_next   = front_reg;
    valid_next   = valid_reg;
    pending_next = pending_reg;
    angle_next   = angle_reg;
    len_next     = len_reg;
    en_next      = en_reg;
    cur_next     = cur_reg;
    idx_next     = idx_reg;
    row_next     = row_reg;
    r_next       = r_reg;
    sin_neg_next = sin_neg_reg;
    cos_neg_next = cos_neg_reg;
    sin_mag_next = sin_mag_reg;
    cos_mag_next = cos_mag_reg;
    trig_start   = 1'b0;
    trig_angle   = 16'd0;
    frame_done   = 1'b0;

    if (req_edge && (state_reg != IDLE)) pending_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (req_edge || pending_reg) begin
          state_next   = CLEAR;
          pending_next = 1'b0;
          angle_next   = hand_angle;
          len_next     = hand_len;
          en_next      = hand_en;
          row_next     = '0;
          idx_next     = '0;
        end
      end
      CLEAR: begin
        row_next = row_reg + 1'b1;
        if (row_reg == ROW_W'(FB_DIM - 1)) state_next = SEL;
      end
      SEL: begin
        if (found) begin
          cur_next   = CUR_W'(sel_pos);
          idx_next   = sel_pos + 1'b1;
          state_next = REQ;
        end else begin
          state_next = SWAP;
        end
      end
      REQ: begin
        trig_start = 1'b1;
        trig_angle = {7'd0, clamp_ang};
        state_next = WAIT;
      end
      WAIT: begin
        if (trig_done) begin
          sin_neg_next = trig_sin[15];
          cos_neg_next = trig_cos[15];
          sin_mag_next = mag17(trig_sin);
          cos_mag_next = mag17(trig_cos);
          r_next       = LEN_W'(1);
          state_next   = PLOT;
        end
      end
      PLOT: begin
        if (r_reg == len_arr[cur_reg]) state_next = SEL;
        else r_next = r_reg + 1'b1;
      end
      SWAP: begin
        front_next = ~front_reg;
        valid_next = 1'b1;
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      front_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      pending_reg <= 1'b0;
      req_d_reg   <= 1'b0;
      angle_reg   <= '0;
      len_reg     <= '0;
      en_reg      <= '0;
      cur_reg     <= '0;
      idx_reg     <= '0;
      row_reg     <= '0;
      r_reg       <= '0;
      sin_neg_reg <= 1'b0;
      cos_neg_reg <= 1'b0;
      sin_mag_reg <= '0;
      cos_mag_reg <= '0;
      pixel_bw    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      front_reg   <= front_next;
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
      req_d_reg   <= frame_req;
      angle_reg   <= angle_next;
      len_reg     <= len_next;
      en_reg      <= en_next;
      cur_reg     <= cur_next;
      idx_reg     <= idx_next;
      row_reg     <= row_next;
      r_reg       <= r_next;
      sin_neg_reg <= sin_neg_next;
      cos_neg_reg <= cos_neg_next;
      sin_mag_reg <= sin_mag_next;
      cos_mag_reg <= cos_mag_next;
      pixel_bw    <= pixel_next;
    end
  end

  // Row-wide storage: bank in the top address bit; only the back bank is ever written.
  logic [FB_DIM-1:0] fb_mem [2*FB_DIM];

  always_ff @(posedge clk) begin
    if (state_reg == CLEAR)
      fb_mem[{~front_reg, row_reg}] <= '0;
    else if ((state_reg == PLOT) && plot_ok)
      fb_mem[{~front_reg, y_pos[ROW_W-1:0]}][x_pos[ROW_W-1:0]] <= 1'b1;
  end

  logic [9:0]       h_adj, v_adj;
  logic [ROW_W-1:0] h_col, v_row;
  logic             in_area;
  assign h_adj   = horizCounter - x_offset;
  assign v_adj   = vertCounter - y_offset;
  assign in_area = (h_adj < AREA_V) && (v_adj < AREA_V);
  assign h_col   = ROW_W'(h_adj / SCALE_V);
  assign v_row   = ROW_W'(v_adj / SCALE_V);
  assign pixel_next = in_area & valid_reg & fb_mem[{front_reg, v_row}][h_col];

endmodule

// File: tb/tb_hand_raster_engine.sv
// Bench for hand_raster_engine: sin/cos responder with programmable latency, a
// pixel-level reference renderer, and full-frame scan-out comparison.
module tb_hand_raster_engine;

  localparam int FB_DIM    = 64;
  localparam int SCALE     = 7;
  localparam int NUM_HANDS = 4;
  localparam int LEN_W     = 6;
  localparam int FRAC      = 14;
  localparam int BUDGET    = 6000;
  localparam real PI       = 3.14159265358979;

  logic                       clk;
  logic                       reset;
  logic                       frame_req;
  logic [9*NUM_HANDS-1:0]     hand_angle;
  logic [LEN_W*NUM_HANDS-1:0] hand_len;
  logic [NUM_HANDS-1:0]       hand_en;
  logic                       trig_start;
  logic [15:0]                trig_angle;
  logic [15:0]                trig_sin;
  logic [15:0]                trig_cos;
  logic                       trig_done;
  logic [9:0]                 horizCounter, vertCounter, x_offset, y_offset;
  logic                       pixel_bw, busy, frame_done;

  hand_raster_engine #(
    .FB_DIM(FB_DIM), .SCALE(SCALE), .NUM_HANDS(NUM_HANDS), .LEN_W(LEN_W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .reset(reset), .frame_req(frame_req),
    .hand_angle(hand_angle), .hand_len(hand_len), .hand_en(hand_en),
    .trig_start(trig_start), .trig_angle(trig_angle),
    .trig_sin(trig_sin), .trig_cos(trig_cos), .trig_done(trig_done),
    .horizCounter(horizCounter), .vertCounter(vertCounter),
    .x_offset(x_offset), .y_offset(y_offset),
    .pixel_bw(pixel_bw), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int trig_lat = 1;
  int start_viol = 0;
  int obs_angles[$];
  int exp_angles[$];
  int fd_count = 0;
  int resp_angle;

  int h_ang[NUM_HANDS];
  int h_len[NUM_HANDS];
  bit h_en[NUM_HANDS];
  bit exp_fb[FB_DIM][FB_DIM];
  bit obs_fb[FB_DIM][FB_DIM];
  int out_ones;

  function automatic int sin_q(int a);
    return $rtoi($sin(real'(a) * PI / 180.0) * 16384.0);
  endfunction

  function automatic int cos_q(int a);
    return $rtoi($cos(real'(a) * PI / 180.0) * 16384.0);
  endfunction

  // sin/cos unit: answers each request trig_lat cycles later.
  always begin
    @(negedge clk);
    if (trig_start === 1'b1) begin
      resp_angle = int'(trig_angle);
      obs_angles.push_back(resp_angle);
      for (int k = 1; k <= trig_lat; k++) begin
        @(negedge clk);
        if (trig_start === 1'b1) start_viol++;
      end
      trig_sin  = 16'(sin_q(resp_angle));
      trig_cos  = 16'(cos_q(resp_angle));
      trig_done = 1'b1;
      @(posedge clk);
      #1;
      trig_done = 1'b0;
      trig_sin  = 16'($urandom);
      trig_cos  = 16'($urandom);
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  // Reference renderer: plain geometry on the sampled hand list.
  function automatic int model_frame(int lat);
    int total, a, s, c, os, oc, x, y;
    for (int yy = 0; yy < FB_DIM; yy++)
      for (int xx = 0; xx < FB_DIM; xx++) exp_fb[yy][xx] = 1'b0;
    exp_angles.delete();
    total = FB_DIM + 2;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (h_en[i] && h_len[i] > 0) begin
        a = (h_ang[i] > 359) ? 359 : h_ang[i];
        exp_angles.push_back(a);
        s = sin_q(a);
        c = cos_q(a);
        total += 2 + lat + h_len[i];
        for (int r = 1; r <= h_len[i]; r++) begin
          os = (s < 0) ? -((r * (-s)) >> FRAC) : ((r * s) >> FRAC);
          oc = (c < 0) ? -((r * (-c)) >> FRAC) : ((r * c) >> FRAC);
          x = FB_DIM / 2 + os;
          y = FB_DIM / 2 - oc;
          if (x >= 0 && x < FB_DIM && y >= 0 && y < FB_DIM) exp_fb[y][x] = 1'b1;
        end
      end
    end
    return total;
  endfunction

  function automatic int diff_count(output int fx, output int fy);
    int d = 0;
    fx = -1;
    fy = -1;
    for (int y = 0; y < FB_DIM; y++)
      for (int x = 0; x < FB_DIM; x++)
        if (obs_fb[y][x] != exp_fb[y][x]) begin
          if (d == 0) begin fx = x; fy = y; end
          d++;
        end
    return d;
  endfunction

  function automatic bit angles_match();
    if (obs_angles.size() != exp_angles.size()) return 1'b0;
    foreach (exp_angles[i]) if (obs_angles[i] != exp_angles[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_hands();
    for (int i = 0; i < NUM_HANDS; i++) begin
      hand_angle[9*i +: 9]         = 9'(h_ang[i]);
      hand_len[LEN_W*i +: LEN_W]   = LEN_W'(h_len[i]);
      hand_en[i]                   = h_en[i];
    end
  endtask

  task automatic set_one_hand(int ang, int len);
    for (int i = 0; i < NUM_HANDS; i++) begin
      h_ang[i] = int'($urandom_range(0, 511));
      h_len[i] = int'($urandom_range(0, 63));
      h_en[i]  = 1'b0;
    end
    h_ang[0] = ang;
    h_len[0] = len;
    h_en[0]  = 1'b1;
  endtask

  task automatic rand_hands();
    for (int i = 0; i < NUM_HANDS; i++) begin
      h_ang[i] = int'($urandom_range(0, 511));
      h_len[i] = int'($urandom_range(0, 63));
      h_en[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_frame(output int cycles, output bit timeout);
    cycles = 0;
    obs_angles.delete();
    @(negedge clk);
    frame_req = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (frame_done !== 1'b1 && cycles < BUDGET);
    timeout = (frame_done !== 1'b1);
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  // Reads the whole front buffer through the scaled scan-out, plus off-area probes.
  task automatic scan_frame();
    int ha, va;
    x_offset = 10'($urandom);
    y_offset = 10'($urandom);
    for (int y = 0; y < FB_DIM; y++)
      for (int x = 0; x < FB_DIM; x++) begin
        @(negedge clk);
        horizCounter = x_offset + 10'(x * SCALE + int'($urandom_range(0, SCALE - 1)));
        vertCounter  = y_offset + 10'(y * SCALE + int'($urandom_range(0, SCALE - 1)));
        @(posedge clk);
        #1;
        obs_fb[y][x] = pixel_bw;
      end
    out_ones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        ha = int'($urandom_range(FB_DIM * SCALE, 1023));
        va = int'($urandom_range(0, FB_DIM * SCALE - 1));
      end else begin
        ha = int'($urandom_range(0, FB_DIM * SCALE - 1));
        va = int'($urandom_range(FB_DIM * SCALE, 1023));
      end
      horizCounter = x_offset + 10'(ha);
      vertCounter  = y_offset + 10'(va);
      @(posedge clk);
      #1;
      if (pixel_bw === 1'b1) out_ones++;
    end
  endtask

  task automatic test_reset();
    int ones;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    vectors++;
    if (trig_start !== 1'b0) begin miscompares++; $display("FAIL reset_trig_start: got %b required 0", trig_start); end
    vectors++;
    if (trig_angle !== 16'd0) begin miscompares++; $display("FAIL reset_trig_angle: got %0d required 0", trig_angle); end
    ones = 0;
    x_offset = 10'd20;
    y_offset = 10'd30;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      horizCounter = 10'd20 + 10'($urandom_range(0, FB_DIM * SCALE - 1));
      vertCounter  = 10'd30 + 10'($urandom_range(0, FB_DIM * SCALE - 1));
      @(posedge clk);
      #1;
      if (pixel_bw !== 1'b0) ones++;
    end
    vectors++;
    if (ones !== 0) begin miscompares++; $display("FAIL preswap_pixel: got %0d lit samples required 0", ones); end
    $display("reset: %0d vectors so far", vectors);
  endtask

  task automatic check_frame(string name, int cycles, bit timeout, int exp_cyc);
    int d, fx, fy;
    vectors++;
    if (timeout || cycles !== exp_cyc) begin
      miscompares++;
      $display("FAIL %s_cycles: got %0d (timeout=%0b) required %0d", name, cycles, timeout, exp_cyc);
    end
    vectors++;
    if (!angles_match()) begin
      miscompares++;
      $display("FAIL %s_trig_angles: got %0d requests required %0d", name, obs_angles.size(), exp_angles.size());
    end
    scan_frame();
    d = diff_count(fx, fy);
    vectors++;
    if (d !== 0) begin
      miscompares++;
      $display("FAIL %s_image: got %0d differing pixels (first x=%0d y=%0d) required 0", name, d, fx, fy);
    end
    vectors++;
    if (out_ones !== 0) begin
      miscompares++;
      $display("FAIL %s_outside_area: got %0d lit samples required 0", name, out_ones);
    end
    $display("%s: frame of %0d cycles, %0d pixels expected lit", name, cycles, count_exp());
  endtask

  function automatic int count_exp();
    int n = 0;
    for (int y = 0; y < FB_DIM; y++)
      for (int x = 0; x < FB_DIM; x++) n += int'(exp_fb[y][x]);
    return n;
  endfunction

  task automatic test_single_hand();
    int cyc, exp_cyc, fd0;
    bit to;
    set_one_hand(0, 20);
    drive_hands();
    trig_lat = 1;
    exp_cyc = model_frame(1);
    fd0 = fd_count;
    run_frame(cyc, to);
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (fd_count - fd0 !== 1) begin miscompares++; $display("FAIL single_frame_done_count: got %0d required 1", fd_count - fd0); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b required 0", busy); end
    check_frame("single", cyc, to, exp_cyc);
  endtask

  task automatic test_plus();
    int cyc, exp_cyc;
    bit to;
    for (int i = 0; i < NUM_HANDS; i++) begin
      h_ang[i] = 90 * i;
      h_len[i] = 31;
      h_en[i]  = 1'b1;
    end
    drive_hands();
    trig_lat = 3;
    exp_cyc = model_frame(3);
    run_frame(cyc, to);
    check_frame("plus", cyc, to, exp_cyc);
    vectors++;
    if (obs_fb[FB_DIM/2][FB_DIM/2] !== 1'b0) begin miscompares++; $display("FAIL plus_centre: got %b required 0", obs_fb[FB_DIM/2][FB_DIM/2]); end
  endtask

  task automatic test_edge45();
    int cyc, exp_cyc;
    bit to;
    set_one_hand(45, 63);
    drive_hands();
    trig_lat = 2;
    exp_cyc = model_frame(2);
    run_frame(cyc, to);
    check_frame("edge45", cyc, to, exp_cyc);
  endtask

  task automatic test_blank();
    int cyc, exp_cyc;
    bit to;
    set_one_hand(100, 0);
    for (int i = 1; i < NUM_HANDS; i++) h_len[i] = 40;
    drive_hands();
    trig_lat = 4;
    exp_cyc = model_frame(4);
    run_frame(cyc, to);
    check_frame("blank", cyc, to, exp_cyc);
  endtask

  task automatic test_random();
    int cyc, exp_cyc, lat;
    bit to;
    for (int it = 0; it < 3; it++) begin
      rand_hands();
      drive_hands();
      lat = int'($urandom_range(1, 6));
      trig_lat = lat;
      exp_cyc = model_frame(lat);
      run_frame(cyc, to);
      check_frame($sformatf("random%0d", it), cyc, to, exp_cyc);
    end
  endtask

  // Three request edges while busy plus new hand inputs: one follow-up frame, new inputs.
  task automatic test_back_to_back();
    int ta, tb, cyc, limit, d, fx, fy, fd0;
    int done_at[$];
    int a_angles[$];
    trig_lat = 20;
    rand_hands();
    h_en[1] = 1'b1;
    h_len[1] = 25;
    drive_hands();
    ta = model_frame(20);
    a_angles = exp_angles;
    rand_hands();
    h_en[2] = 1'b1;
    h_len[2] = 33;
    tb = model_frame(20);
    obs_angles.delete();
    start_viol = 0;
    fd0 = fd_count;
    cyc = 0;
    limit = ta + 1 + tb + 300;
    @(negedge clk);
    frame_req = 1'b1;
    while (cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) done_at.push_back(cyc);
      @(negedge clk);
      if (cyc == 3) drive_hands();
      if (cyc >= 5 && cyc <= 10) frame_req = (cyc % 2 == 0);
    end
    frame_req = 1'b0;
    vectors++;
    if (done_at.size() !== 2 || fd_count - fd0 !== 2) begin
      miscompares++;
      $display("FAIL b2b_frame_count: got %0d frames required 2", done_at.size());
    end
    vectors++;
    if (done_at.size() < 1 || done_at[0] !== ta) begin
      miscompares++;
      $display("FAIL b2b_first_time: got %0d required %0d", (done_at.size() > 0) ? done_at[0] : -1, ta);
    end
    vectors++;
    if (done_at.size() < 2 || done_at[1] - done_at[0] !== tb + 1) begin
      miscompares++;
      $display("FAIL b2b_second_time: got %0d required %0d", (done_at.size() > 1) ? done_at[1] - done_at[0] : -1, tb + 1);
    end
    vectors++;
    if (start_viol !== 0) begin miscompares++; $display("FAIL b2b_trig_restart: got %0d reassertions required 0", start_viol); end
    exp_angles = {a_angles, exp_angles};
    vectors++;
    if (!angles_match()) begin
      miscompares++;
      $display("FAIL b2b_trig_angles: got %0d requests required %0d", obs_angles.size(), exp_angles.size());
    end
    scan_frame();
    d = diff_count(fx, fy);
    vectors++;
    if (d !== 0) begin
      miscompares++;
      $display("FAIL b2b_image: got %0d differing pixels (first x=%0d y=%0d) required 0", d, fx, fy);
    end
    $display("back_to_back: frames at cycles %0d, expected %0d and %0d", done_at.size(), ta, ta + 1 + tb);
  endtask

  task automatic test_reset_mid_plot();
    int cyc, exp_cyc, ones;
    bit to;
    set_one_hand(0, 20);
    drive_hands();
    trig_lat = 1;
    void'(model_frame(1));
    run_frame(cyc, to);
    @(negedge clk);
    x_offset = 10'd0;
    y_offset = 10'd0;
    horizCounter = 10'((FB_DIM / 2) * SCALE + 3);
    vertCounter  = 10'(20 * SCALE + 3);
    @(posedge clk);
    #1;
    vectors++;
    if (pixel_bw !== 1'b1) begin miscompares++; $display("FAIL rst_pre_pixel: got %b required 1", pixel_bw); end
    set_one_hand(180, 60);
    drive_hands();
    @(negedge clk);
    frame_req = 1'b1;
    repeat (75) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, trig_start, frame_done, pixel_bw} !== 4'b0000 || trig_angle !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_outputs: got busy=%b start=%b done=%b pix=%b angle=%0d required all 0",
               busy, trig_start, frame_done, pixel_bw, trig_angle);
    end
    frame_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (pixel_bw !== 1'b0) ones++;
    end
    vectors++;
    if (ones !== 0) begin miscompares++; $display("FAIL rst_pixel_hold: got %0d lit cycles required 0", ones); end
    set_one_hand(90, 10);
    drive_hands();
    trig_lat = 2;
    exp_cyc = model_frame(2);
    run_frame(cyc, to);
    check_frame("after_reset", cyc, to, exp_cyc);
  endtask

  initial begin
    reset        = 1'b1;
    frame_req    = 1'b0;
    hand_angle   = '0;
    hand_len     = '0;
    hand_en      = '0;
    trig_sin     = 16'd0;
    trig_cos     = 16'd0;
    trig_done    = 1'b0;
    horizCounter = 10'd0;
    vertCounter  = 10'd0;
    x_offset     = 10'd0;
    y_offset     = 10'd0;
    test_reset();
    test_single_hand();
    test_plus();
    test_edge45();
    test_blank();
    test_back_to_back();
    test_random();
    test_reset_mid_plot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
